// File: rtl/event_generator_if.sv
// Operator-facing board signals of the event generator: keys, switches, pulse output and display.
interface event_generator_if;
    logic [3:0] KEY;
    logic [9:0] SW;
    logic       PULSE_OUT;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [9:0] LEDR;

    modport master (
        output KEY,
        output SW,
        input  PULSE_OUT,
        input  HEX0,
        input  HEX1,
        input  LEDR
    );

    modport slave (
        input  KEY,
        input  SW,
        output PULSE_OUT,
        output HEX0,
        output HEX1,
        output LEDR
    );
endinterface

// File: rtl/event_generator.sv
// Fires a burst of N fixed-width pulses on PULSE_OUT when KEY[0] is released; KEY[1] aborts.
// Remaining count drives two hex digits, busy/done/latched N drive the LEDs.
module event_generator #(
    parameter int unsigned HIGH_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 25_000_000
) (
    input logic             CLOCK_50,
    input logic             reset,
    event_generator_if.slave bus
);

    localparam int unsigned MaxCycles = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [TimerW-1:0] HighLoad = TimerW'(HIGH_CYCLES - 1);
    localparam logic [TimerW-1:0] GapLoad  = TimerW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StGap
    } state_e;

    state_e            state_q, state_d;
    logic [TimerW-1:0] timer_q, timer_d;
    logic [7:0]        remaining_q, remaining_d;
    logic [7:0]        n_lat_q, n_lat_d;
    logic              done_q, done_d;
    logic              pulse_q, pulse_d;
    logic [2:0]        start_sync_q;
    logic [2:0]        abort_sync_q;
    logic              start;
    logic              abort;
    logic [7:0]        sw_count;

    // Key released (active-low button going high) after the first two synchroniser stages.
    assign start    = start_sync_q[1] & ~start_sync_q[2];
    assign abort    = abort_sync_q[1] & ~abort_sync_q[2];
    assign sw_count = bus.SW[7:0];

    logic unused_inputs;
    assign unused_inputs = ^{bus.KEY[3:2], bus.SW[9:8]};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            remaining_q  <= '0;
            n_lat_q      <= '0;
            done_q       <= 1'b0;
            pulse_q      <= 1'b0;
            start_sync_q <= 3'b111;
            abort_sync_q <= 3'b111;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            remaining_q  <= remaining_d;
            n_lat_q      <= n_lat_d;
            done_q       <= done_d;
            pulse_q      <= pulse_d;
            start_sync_q <= {start_sync_q[1:0], bus.KEY[0]};
            abort_sync_q <= {abort_sync_q[1:0], bus.KEY[1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        n_lat_d     = n_lat_q;
        done_d      = done_q;
        pulse_d     = pulse_q;

        if (abort) begin
            // Abort beats a same-cycle start; in idle it only clears done.
            done_d = 1'b0;
            if (state_q != StIdle) begin
                state_d     = StIdle;
                remaining_d = '0;
                timer_d     = '0;
                pulse_d     = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    pulse_d = 1'b0;
                    if (start && (sw_count != 8'd0)) begin
                        n_lat_d     = sw_count;
                        remaining_d = sw_count;
                        timer_d     = HighLoad;
                        done_d      = 1'b0;
                        state_d     = StHigh;
                        pulse_d     = 1'b1;
                    end
                end
                StHigh: begin
                    if (timer_q == '0) begin
                        remaining_d = (remaining_q != 8'd0) ? remaining_q - 8'd1 : 8'd0;
                        pulse_d     = 1'b0;
                        if (remaining_q <= 8'd1) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end else begin
                            timer_d = GapLoad;
                            state_d = StGap;
                        end
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                StGap: begin
                    if (timer_q == '0) begin
                        timer_d = HighLoad;
                        state_d = StHigh;
                        pulse_d = 1'b1;
                    end else begin
                        timer_d = timer_q - 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    pulse_d = 1'b0;
                end
            endcase
        end
    end

    function automatic logic [6:0] seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign bus.PULSE_OUT = pulse_q;
    assign bus.HEX0      = seg(remaining_q[3:0]);
    assign bus.HEX1      = seg(remaining_q[7:4]);
    assign bus.LEDR      = {n_lat_q, done_q, (state_q != StIdle)};

endmodule

// File: doc/event_generator.md
# event_generator

Test-stimulus source that emits a programmed number of clean, fixed-width pulses on `PULSE_OUT`, the driving end of the event-counting path on the DE-board. The operator sets a pulse count on the switches and presses a key to fire a burst. The key inputs are synchronised and edge-detected. The remaining-pulse count is shown on two 7-segment digits, and busy/done status is shown on the LEDs. `PULSE_OUT` is wired to the counter board's count input so a counter can be exercised with a known event total.

## Interface
- `HIGH_CYCLES`, default 25_000_000: `PULSE_OUT` high time per pulse, in clock cycles. Must be ≥1.
- `GAP_CYCLES`, default 25_000_000: `PULSE_OUT` low time between consecutive pulses, in clock cycles. Must be ≥1.
- `CLOCK_50`  in  1  system clock, 50 MHz.
- `reset`  in  1  asynchronous, active-high reset.
- `KEY`  in  4  push buttons, active-low. KEY[0] = start, KEY[1] = abort, KEY[3:2] unused.
- `SW`  in  10  SW[7:0] = pulse count N. SW[9:8] unused.
- `PULSE_OUT`  out  1  registered pulse train.
- `HEX0`  out  7  low hex digit of remaining count, active-low segments.
- `HEX1`  out  7  high hex digit of remaining count, active-low segments.
- `LEDR`  out  10  LEDR[0] = busy, LEDR[1] = done, LEDR[9:2] = latched N.

## Operation
- **Key synchronisers.** KEY[0] and KEY[1] each pass through a 3-flop synchroniser, with reset value 3'b111 (released).
  - Event = s[1] & ~s[2], i.e. a rising edge, which is button release.
  - Each event is one cycle wide: `start` from KEY[0], `abort` from KEY[1].
- **FSM states:** IDLE, HIGH, GAP.
- **IDLE**
  - `PULSE_OUT`=0.
  - On `start` with SW[7:0] ≠ 0:
    - latch N = SW[7:0] into `n_lat` and into `remaining`;
    - load timer = HIGH_CYCLES−1;
    - clear done;
    - go to HIGH.
  - `start` with SW[7:0] = 0 is ignored: no state change, and done is unchanged.
- **HIGH**
  - `PULSE_OUT`=1 and the timer decrements each cycle.
  - When timer = 0, `remaining` decrements by 1. Then:
    - if `remaining` was 1: go to IDLE and set done;
    - otherwise: load timer = GAP_CYCLES−1 and go to GAP.
- **GAP**
  - `PULSE_OUT`=0 and the timer decrements each cycle.
  - When timer = 0: load timer = HIGH_CYCLES−1 and go to HIGH.
- **Abort.** `abort` in HIGH or GAP forces IDLE, `remaining`=0, done=0 and `PULSE_OUT`=0 on the next edge. `abort` in IDLE clears done only.
- **Simultaneous events.** If `start` and `abort` arrive in the same cycle, abort wins. `start` while in HIGH or GAP is ignored, and SW changes during a burst have no effect.
- **Widths.**
  - Timer: $clog2(max(HIGH_CYCLES, GAP_CYCLES)) bits, minimum 1.
  - `remaining` and `n_lat`: 8 bits. `remaining` never wraps; it stops at 0.
- **Display.** HEX0 = seg(`remaining`[3:0]) and HEX1 = seg(`remaining`[7:4]), combinational from registers.
  - Team hex font: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- **LEDs.** LEDR[0] = (state ≠ IDLE), LEDR[1] = done, LEDR[9:2] = `n_lat`. `n_lat` holds after completion or abort until the next accepted start.

## Timing
- **Reset values.** `reset` asserted (asynchronous) gives state IDLE, `PULSE_OUT`=0, `remaining`=0, `n_lat`=0, done=0, timer=0, synchronisers=111. Outputs follow: HEX0=HEX1=1000000, LEDR=0.
- **Start latency.** If KEY[0] is first sampled high at edge k, `start` is high between edge k+1 and edge k+2, and `PULSE_OUT` is 1 from edge k+2.
- **Pulse shape.** Each pulse is high for exactly HIGH_CYCLES cycles. Gaps are low for exactly GAP_CYCLES cycles.
- **Burst duration.** N·HIGH_CYCLES + (N−1)·GAP_CYCLES cycles from first rise to last fall.
- **Count update.** `remaining` updates on the same edge that `PULSE_OUT` falls.
- **Completion.** done and busy=0 are set on the edge where the last pulse falls.
- **Abort latency.** `abort` has the same 2-edge synchroniser latency as `start`, followed by 1 edge to the outputs.
- **Reset mid-burst.** `PULSE_OUT` goes to 0 immediately (asynchronously), with no partial-pulse completion.

## Test plan
All scenarios use HIGH_CYCLES=3 and GAP_CYCLES=2.
- **Reset values.** Assert `reset` → `PULSE_OUT`=0, HEX0=HEX1=1000000, LEDR=0. Hold KEY=4'hF for 10 cycles → no state change.
- **Normal burst.**
  - Stimulus: SW=3, press then release KEY[0].
  - Required waveform: 3 pulses of 3 cycles high with 2-cycle gaps, total 13 cycles.
  - Required display: HEX0 goes 0110000→0100100→1111001→1000000, changing at each falling edge.
  - Required LEDs: busy during the burst; afterwards LEDR[1]=1 and LEDR[9:2]=3.
- **Zero count.** SW=0 then start → `PULSE_OUT` stays 0 for 20 cycles and LEDR[1:0]=00.
- **Abort mid-burst.** SW=5, start, release KEY[1] during the 2nd pulse → `PULSE_OUT`=0 within 3 edges of the sync event, HEX=1000000/1000000, LEDR[1:0]=00, LEDR[9:2]=5.
- **Start while busy.** SW=2, start, then change SW to 7 and press start again during the 1st gap → exactly 2 pulses, and LEDR[9:2]=2.
- **Full count and reset mid-burst.**
  - SW=8'hFF → HEX1=HEX0=0001110 at start; 255 pulses; final HEX=1000000 and done=1.
  - Assert `reset` between two clock edges while `PULSE_OUT`=1 → `PULSE_OUT` drops before the next edge, and all outputs take their reset values.
